sprite_rom_engine: RTL and testbench
====================================

Name: sprite_rom_engine

Overview:
- Parametrised sprite renderer that replaces the fixed combinational ball bitmaps.
- Holds up to 4 selectable SIZE x SIZE monochrome sprites, with integer up-scaling and horizontal/vertical mirroring.
- Supports optional frame-synchronous animation that cycles through the sprites.
- Sits between the VGA pixel counter and the RGB mux; outputs a registered per-pixel "sprite on" flag with fixed 2-cycle latency.

Parameters:
- SIZE, 16, sprite edge in pixels; legal values 8 or 16.
- NUM_SPRITES, 4, number of active sprite slots; range 1..4.
- SCALE_LOG2, 0, on-screen magnification 2^SCALE_LOG2; range 0..2.
- COORD_W, 10, width of pixel and origin coordinates.
- ANIM_DIV, 8, frames per animation step; must be >= 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pix_en  in  1  pixel strobe; pix_x/pix_y are valid this cycle
- pix_x  in  COORD_W  current pixel column
- pix_y  in  COORD_W  current pixel row
- frame_start  in  1  one-cycle pulse at start of vertical blank
- spr_x  in  COORD_W  sprite top-left column (sampled on frame_start)
- spr_y  in  COORD_W  sprite top-left row (sampled on frame_start)
- sprite_sel  in  2  static sprite index (sampled on frame_start)
- flip_h  in  1  mirror left/right (sampled on frame_start)
- flip_v  in  1  mirror top/bottom (sampled on frame_start)
- anim_en  in  1  1 = auto-cycle sprites; 0 = use sprite_sel
- pix_valid  out  1  pix_en delayed 2 cycles
- pix_on  out  1  sprite pixel lit, aligned with pix_valid
- cur_sprite  out  2  sprite index currently rendered

Behaviour:
- Reset (asynchronous, rst_n=0): pix_on=0, pix_valid=0, cur_sprite=0, all latched shadow registers=0, animation counter=0, pipeline registers cleared. Reset asserted mid-frame drops any in-flight pixels.
- Shadow latch:
  - On any clk edge with frame_start=1, spr_x, spr_y, sprite_sel, flip_h and flip_v are copied to shadow registers.
  - A pixel presented in the same cycle as frame_start uses the old shadow values.
  - Between frame_start pulses, input changes have no effect. No mid-frame tearing.
- Animation:
  - anim_en=0: cur_sprite = shadow sprite_sel mod NUM_SPRITES, updated on frame_start. The counter holds at 0.
  - anim_en=1: the counter increments on each frame_start. When it reaches ANIM_DIV-1 it wraps to 0 and cur_sprite advances by 1, wrapping NUM_SPRITES-1 -> 0. Otherwise cur_sprite is unchanged.
  - anim_en 1->0: the counter is cleared; cur_sprite reloads from sprite_sel at the next frame_start.
- Stage 1 (registered, advances every cycle; bubble when pix_en=0):
  - dx = pix_x - spr_x, dy = pix_y - spr_y, computed as COORD_W+1-bit signed.
  - inside = dx>=0 and dy>=0 and dx < SIZE<<SCALE_LOG2 and dy < SIZE<<SCALE_LOG2.
  - col = dx>>SCALE_LOG2, row = dy>>SCALE_LOG2, each log2(SIZE) bits.
  - flip_h: col = SIZE-1-col. flip_v: row = SIZE-1-row.
  - Register inside, row, col, cur_sprite and pix_en.
- Stage 2 (registered):
  - Look up the ROM word [sprite][row] and take the bit at index SIZE-1-col (MSB = leftmost column).
  - pix_on = inside & pix_en_d1 & bit. pix_valid = pix_en_d1.
  - Total latency: pix_en at cycle N -> pix_valid/pix_on at cycle N+2.
- Boundaries:
  - Sprite partially off-screen (origin near the coordinate maximum): no wrap. Pixels with dx >= box width are off.
  - pix_x < spr_x is off; no aliasing via unsigned wrap.
- ROM contents, rows top to bottom, hex:
  - SIZE=8:
    - S0 disc: 3C 7E FF FF FF FF 7E 3C
    - S1 slotted ball: 24 66 E7 00 00 E7 66 24
    - S2 outline: FF then 81 x6 then FF
    - S3 solid: FF x8
  - SIZE=16:
    - S0 disc: 07E0 0FF0 0FF0 1FF8 3FFC 7FFE FFFF x5 7FFE 3FFC 1FF8 0FF0 07E0
    - S1: the 8x8 slotted ball with each bit doubled in both axes
    - S2 outline: FFFF then 8001 x14 then FFFF
    - S3 solid: FFFF x16

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles, release -> pix_on=0, pix_valid=0, cur_sprite=0. Assert rst_n=0 mid-stream -> outputs go to 0 immediately (asynchronous).
- Latency/disc (SIZE=16, SCALE=0): spr_x=100, spr_y=50, sprite_sel=0, frame_start; sweep row y=50 with pix_en=1 -> pix_on=1 exactly for x=105..110, each appearing 2 cycles after its pix_en.
- Flip and scale (SIZE=8, SCALE_LOG2=1): sprite_sel=2, spr=(0,0), flip_h=1 -> box is 16x16; row y=2 lit at x=0,1,14,15 only. With S1 and flip_v=1, y=0..1 reproduces source row 7 (24h).
- Tearing guard: change spr_x from 100 to 200 mid-frame without frame_start -> rendering stays at 100 until the next frame_start. A pixel issued in the same cycle as frame_start still renders at 100.
- Animation (ANIM_DIV=2, NUM_SPRITES=3, anim_en=1): issue 6 frame_start pulses -> cur_sprite sequence 0,1,1,2,2,0.
- Clipping: spr_x=1020, COORD_W=10, SIZE=16 -> pixels x=1020..1023 are rendered per column; x=0..11 never lit.

Source files
------------

// File: rtl/sprite_rom_engine.sv
// Sprite renderer: frame-latched position/orientation, animated sprite select,
// and a two-stage pipeline from pixel coordinates to a registered "sprite on" flag.
module sprite_rom_engine #(
    parameter int SIZE        = 16,
    parameter int NUM_SPRITES = 4,
    parameter int SCALE_LOG2  = 0,
    parameter int COORD_W     = 10,
    parameter int ANIM_DIV    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_en,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic               frame_start,
    input  logic [COORD_W-1:0] spr_x,
    input  logic [COORD_W-1:0] spr_y,
    input  logic [1:0]         sprite_sel,
    input  logic               flip_h,
    input  logic               flip_v,
    input  logic               anim_en,
    output logic               pix_valid,
    output logic               pix_on,
    output logic [1:0]         cur_sprite
);

    localparam int IDX_W = $clog2(SIZE);
    localparam int CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [COORD_W:0]  BOX      = (COORD_W+1)'(SIZE << SCALE_LOG2);
    localparam logic [1:0]        LAST_SPR = 2'(NUM_SPRITES - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(ANIM_DIV - 1);

    function automatic logic [7:0] rom8(input logic [1:0] spr, input logic [2:0] r);
        rom8 = 8'hFF;
        case (spr)
            2'd0: case (r)
                3'd0, 3'd7: rom8 = 8'h3C;
                3'd1, 3'd6: rom8 = 8'h7E;
                default:    rom8 = 8'hFF;
            endcase
            2'd1: case (r)
                3'd0, 3'd7: rom8 = 8'h24;
                3'd1, 3'd6: rom8 = 8'h66;
                3'd2, 3'd5: rom8 = 8'hE7;
                default:    rom8 = 8'h00;
            endcase
            2'd2:    rom8 = (r == 3'd0 || r == 3'd7) ? 8'hFF : 8'h81;
            default: rom8 = 8'hFF;
        endcase
    endfunction

    function automatic logic [15:0] rom16(input logic [1:0] spr, input logic [3:0] r);
        rom16 = 16'hFFFF;
        case (spr)
            2'd0: case (r)
                4'd0, 4'd15:      rom16 = 16'h07E0;
                4'd1, 4'd2, 4'd14: rom16 = 16'h0FF0;
                4'd3, 4'd13:      rom16 = 16'h1FF8;
                4'd4, 4'd12:      rom16 = 16'h3FFC;
                4'd5, 4'd11:      rom16 = 16'h7FFE;
                default:          rom16 = 16'hFFFF;
            endcase
            // 8x8 slotted ball with every bit doubled in both axes
            2'd1: case (r)
                4'd0, 4'd1, 4'd14, 4'd15:  rom16 = 16'h0C30;
                4'd2, 4'd3, 4'd12, 4'd13:  rom16 = 16'h3C3C;
                4'd4, 4'd5, 4'd10, 4'd11:  rom16 = 16'hFC3F;
                default:                   rom16 = 16'h0000;
            endcase
            2'd2:    rom16 = (r == 4'd0 || r == 4'd15) ? 16'hFFFF : 16'h8001;
            default: rom16 = 16'hFFFF;
        endcase
    endfunction

    logic [COORD_W-1:0] sh_x, sh_y;
    logic               sh_fh, sh_fv;
    logic [CNT_W-1:0]   anim_cnt;
    logic [1:0]         sel_mod;

    assign sel_mod = 2'({1'b0, sprite_sel} % 3'(NUM_SPRITES));

    // cur_sprite doubles as the frame-latched copy of sprite_sel.
    // NOTE: sequential state always uses non-blocking (<=) so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_x       <= '0;
            sh_y       <= '0;
            sh_fh      <= 1'b0;
            sh_fv      <= 1'b0;
            anim_cnt   <= '0;
            cur_sprite <= '0;
        end else begin
            if (frame_start) begin
                sh_x  <= spr_x;
                sh_y  <= spr_y;
                sh_fh <= flip_h;
                sh_fv <= flip_v;
            end
            if (!anim_en) begin
                anim_cnt <= '0;
                if (frame_start) cur_sprite <= sel_mod;
            end else if (frame_start) begin
                if (anim_cnt == LAST_CNT) begin
                    anim_cnt   <= '0;
                    cur_sprite <= (cur_sprite == LAST_SPR) ? 2'd0 : cur_sprite + 2'd1;
                end else begin
                    anim_cnt <= anim_cnt + 1'b1;
                end
            end
        end
    end

    // Extra sign bit keeps pixels left/above the origin from aliasing inside.
    logic [COORD_W:0] dx, dy;
    logic             inside_c;
    logic [IDX_W-1:0] col_c, row_c;

    assign dx = {1'b0, pix_x} - {1'b0, sh_x};
    assign dy = {1'b0, pix_y} - {1'b0, sh_y};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        inside_c = !dx[COORD_W] && !dy[COORD_W] && (dx < BOX) && (dy < BOX);
        col_c    = IDX_W'(dx >> SCALE_LOG2);
        row_c    = IDX_W'(dy >> SCALE_LOG2);
        if (sh_fh) col_c = IDX_W'(SIZE - 1) - col_c;
        if (sh_fv) row_c = IDX_W'(SIZE - 1) - row_c;
    end

    logic             s1_en, s1_inside;
    logic [IDX_W-1:0] s1_col, s1_row;
    logic [1:0]       s1_sprite;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_en     <= 1'b0;
            s1_inside <= 1'b0;
            s1_col    <= '0;
            s1_row    <= '0;
            s1_sprite <= '0;
        end else begin
            s1_en     <= pix_en;
            s1_inside <= inside_c;
            s1_col    <= col_c;
            s1_row    <= row_c;
            s1_sprite <= cur_sprite;
        end
    end

    logic [15:0] rom_word;
    logic [3:0]  bit_idx;

    // MSB of each ROM row is the leftmost column.
    always_comb begin
        rom_word = 16'h0000;
        if (SIZE == 16) rom_word      = rom16(s1_sprite, 4'(s1_row));
        else            rom_word[7:0] = rom8(s1_sprite, 3'(s1_row));
        bit_idx = 4'(SIZE - 1) - 4'(s1_col);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid <= 1'b0;
            pix_on    <= 1'b0;
        end else begin
            pix_valid <= s1_en;
            pix_on    <= s1_en & s1_inside & rom_word[bit_idx];
        end
    end

endmodule

// File: tb/tb_sprite_rom_engine.sv
// Directed bench for sprite_rom_engine: three parameterisations share one
// stimulus bus; a vector table covers pixel streams, hand sequences cover the rest.
module tb_sprite_rom_engine;

    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pix_en, frame_start, flip_h, flip_v, anim_en;
    logic [CW-1:0] pix_x, pix_y, spr_x, spr_y;
    logic [1:0]    sprite_sel;

    logic       valid_a, on_a, valid_b, on_b, valid_c, on_c;
    logic [1:0] cur_a, cur_b, cur_c;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    // a: 16x16, x1, 4 sprites, ANIM_DIV 8
    sprite_rom_engine u_a (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start), .spr_x(spr_x), .spr_y(spr_y), .sprite_sel(sprite_sel),
        .flip_h(flip_h), .flip_v(flip_v), .anim_en(anim_en),
        .pix_valid(valid_a), .pix_on(on_a), .cur_sprite(cur_a)
    );

    // b: 8x8 scaled x2
    sprite_rom_engine #(.SIZE(8), .SCALE_LOG2(1)) u_b (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start), .spr_x(spr_x), .spr_y(spr_y), .sprite_sel(sprite_sel),
        .flip_h(flip_h), .flip_v(flip_v), .anim_en(anim_en),
        .pix_valid(valid_b), .pix_on(on_b), .cur_sprite(cur_b)
    );

    // c: 3 sprites, animation step every 2 frames
    sprite_rom_engine #(.NUM_SPRITES(3), .ANIM_DIV(2)) u_c (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start), .spr_x(spr_x), .spr_y(spr_y), .sprite_sel(sprite_sel),
        .flip_h(flip_h), .flip_v(flip_v), .anim_en(anim_en),
        .pix_valid(valid_c), .pix_on(on_c), .cur_sprite(cur_c)
    );

    typedef struct {
        int   grp;
        int   unit;
        logic fs;
        logic en;
        int   x;
        int   y;
        logic exp_valid;
        logic exp_on;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] outs(input int unit);
        case (unit)
            0:       return {valid_a, on_a};
            1:       return {valid_b, on_b};
            default: return {valid_c, on_c};
        endcase
    endfunction

    task automatic add(input int g, input int u, input logic fs, input logic en,
                       input int x, input int y, input logic ev, input logic eo);
        vecs.push_back('{g, u, fs, en, x, y, ev, eo});
    endtask

    task automatic frame(input int sx, input int sy, input logic [1:0] sel,
                         input logic fh, input logic fv);
        @(negedge clk);
        spr_x       = CW'(sx);
        spr_y       = CW'(sy);
        sprite_sel  = sel;
        flip_h      = fh;
        flip_v      = fv;
        frame_start = 1'b1;
        pix_en      = 1'b0;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    // Streams one group; outputs for vector k are sampled two cycles after it is driven.
    task automatic run_group(input int g);
        int         idx[$];
        vec_t       v;
        logic [1:0] o;
        for (int i = 0; i < vecs.size(); i++)
            if (vecs[i].grp == g) idx.push_back(i);
        for (int k = 0; k < idx.size() + 2; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                v = vecs[idx[k-2]];
                o = outs(v.unit);
                check($sformatf("g%0d valid x=%0d y=%0d", g, v.x, v.y), o[1], v.exp_valid);
                check($sformatf("g%0d on x=%0d y=%0d", g, v.x, v.y), o[0], v.exp_on);
            end
            if (k < idx.size()) begin
                v           = vecs[idx[k]];
                frame_start = v.fs;
                pix_en      = v.en;
                pix_x       = CW'(v.x);
                pix_y       = CW'(v.y);
            end else begin
                frame_start = 1'b0;
                pix_en      = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [1:0] anim_seq [6];
        anim_seq = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0};

        // group 1: disc at (100,50), 16x16, row 0 = 07E0
        for (int x = 98; x <= 113; x++) add(1, 0, 0, 1, x, 50, 1, x >= 105 && x <= 110);
        add(1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 107, 50, 1, 1);
        add(1, 0, 0, 0, 107, 50, 0, 0);
        add(1, 0, 0, 1, 105, 49, 1, 0);
        add(1, 0, 0, 1, 105, 65, 1, 1);
        add(1, 0, 0, 1, 105, 66, 1, 0);
        // group 2: 8x8 outline x2, flip_h, row y=2 -> source row 1 (81h)
        for (int x = 0; x <= 17; x++) add(2, 1, 0, 1, x, 2, 1, x == 0 || x == 1 || x == 14 || x == 15);
        // group 3: slotted ball x2, flip_v; y=0 -> source row 7 (24h)
        for (int x = 0; x <= 15; x++) add(3, 1, 0, 1, x, 0, 1, x == 4 || x == 5 || x == 10 || x == 11);
        add(3, 1, 0, 1, 5, 1, 1, 1);
        add(3, 1, 0, 1, 4, 4, 1, 1);
        add(3, 1, 0, 1, 6, 4, 1, 0);
        add(3, 1, 0, 1, 4, 6, 1, 0);
        // group 4: spr_x input already 200, shadow still 100
        add(4, 0, 0, 1, 105, 50, 1, 1);
        add(4, 0, 0, 1, 205, 50, 1, 0);
        add(4, 0, 0, 0, 105, 50, 0, 0);
        add(4, 0, 1, 1, 105, 50, 1, 1);
        add(4, 0, 0, 1, 105, 50, 1, 0);
        add(4, 0, 0, 1, 205, 50, 1, 1);
        add(4, 0, 0, 1, 210, 50, 1, 1);
        add(4, 0, 0, 1, 211, 50, 1, 0);
        // group 5: solid sprite clipped at the right screen edge
        for (int x = 1018; x <= 1023; x++) add(5, 0, 0, 1, x, 0, 1, x >= 1020);
        for (int x = 0; x <= 11; x++) add(5, 0, 0, 1, x, 0, 1, 0);

        rst_n = 1'b0;
        pix_en = 1'b0; frame_start = 1'b0; anim_en = 1'b0;
        pix_x = '0; pix_y = '0; spr_x = '0; spr_y = '0;
        sprite_sel = '0; flip_h = 1'b0; flip_v = 1'b0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset pix_valid", valid_a, 0);
        check("reset pix_on", on_a, 0);
        check("reset cur_sprite a", cur_a, 0);
        check("reset cur_sprite b", cur_b, 0);
        check("reset cur_sprite c", cur_c, 0);

        frame(100, 50, 2'd0, 1'b0, 1'b0);
        run_group(1);

        frame(0, 0, 2'd2, 1'b1, 1'b0);
        run_group(2);

        frame(0, 0, 2'd1, 1'b0, 1'b1);
        run_group(3);

        frame(100, 50, 2'd0, 1'b0, 1'b0);
        spr_x = CW'(200);
        run_group(4);

        anim_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            frame(200, 50, 2'd2, 1'b0, 1'b0);
            check($sformatf("anim step %0d cur_sprite", i), cur_c, anim_seq[i]);
        end
        check("anim div8 cur_sprite", cur_a, 0);
        anim_en = 1'b0;
        sprite_sel = 2'd1;
        @(negedge clk);
        check("anim off holds cur_sprite", cur_c, 0);
        frame(200, 50, 2'd1, 1'b0, 1'b0);
        check("anim off reload c", cur_c, 1);
        check("anim off reload a", cur_a, 1);

        frame(1020, 0, 2'd3, 1'b0, 1'b0);
        check("sel 3 on 4 sprites", cur_a, 3);
        check("sel 3 mod 3 sprites", cur_c, 0);
        run_group(5);

        // asynchronous reset with lit pixels in flight
        @(negedge clk);
        pix_en = 1'b1; pix_x = CW'(1021); pix_y = '0;
        repeat (2) @(negedge clk);
        check("pre-reset pix_on", on_a, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset pix_on", on_a, 0);
        check("async reset pix_valid", valid_a, 0);
        check("async reset cur_sprite", cur_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pix_x = CW'(5);
        @(negedge clk);
        check("post-reset pipeline empty", valid_a, 0);
        @(negedge clk);
        check("post-reset pix_valid", valid_a, 1);
        check("post-reset shadow origin", on_a, 1);
        pix_en = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
